pc_fetch_ctrl: RTL

Instruction-fetch sequencer for the 16-bit RISC core. Owns the architectural PC, drives the instruction-memory request, advances the PC by 2 through the PC+2 incrementer, and applies redirects, stalls and halt. Its registered outputs form the IF/ID pipeline register that the decode stage consumes.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_fetch_ctrl_if.sv | 14 +
 rtl/adder_pc.sv | 13 +
 rtl/pc_fetch_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants for the 16-bit RISC core.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int OPC_W   = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch and imem.
// Request and address are registered-state driven; ready may arrive after 0..n wait cycles.
interface pc_fetch_ctrl_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/adder_pc.sv
// 16-bit PC incrementer/decrementer: Y = A + 2 (Sub=0) or A - 2 (Sub=1), modulo 2^16.
// Purely combinational, no backpressure.
module adder_pc (
  input  logic [15:0] A,
  input  logic        Sub,
  output logic [15:0] Y
);

  always_comb begin
    Y = Sub ? (A - 16'd2) : (A + 16'd2);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem requests and loads the IF/ID register.
// One-cycle fetch latency; stall freezes PC and IF/ID, imem wait states insert bubbles.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC    = 16'h0000,
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  pc_fetch_ctrl_if.master    imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus2,
  output logic               halted
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, br_pc;
  logic            accept, is_halt;

  adder_pc u_adder_pc (
    .A   (pc),
    .Sub (1'b0),
    .Y   (pc_inc)
  );

  assign br_pc   = br_target & {{(PC_W-1){1'b1}}, 1'b0};
  assign accept  = (state == FETCH) && imem.imem_ready && !stall && !br_taken;
  assign is_halt = (opcode(imem.imem_rdata) == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (br_taken) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   if (accept && is_halt) state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    imem.imem_req = (state == FETCH);
    halted        = (state == HALT);
  end

  assign imem.imem_addr = pc;

  // A halt word is delivered but the PC stays on it so a resume needs a redirect.
  always_comb begin
    pc_nxt = pc;
    if (br_taken) begin
      pc_nxt = br_pc;
    end else if (accept && !is_halt) begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      pc_plus2    <= '0;
    end else begin
      pc <= pc_nxt;
      if (br_taken) begin
        instr_valid <= 1'b0;
      end else if (!stall) begin
        if (accept) begin
          instr_valid <= 1'b1;
          instr       <= imem.imem_rdata;
          pc_out      <= pc;
          pc_plus2    <= pc_inc;
        end else begin
          instr_valid <= 1'b0;
        end
      end
    end
  end

endmodule
